rps_player: RTL
===============

// Module: rps_player
// PURPOSE
//  Player-side transmitter for the rock-paper-scissors arbitration interface.
//  Generates one move per round, either pseudo-random from an LFSR or a fixed
//  programmed move. Presents the move as one-hot r/p/s and raises go. Holds the
//  move until the arbiter's busy pulse completes, then counts the round.
//  One instance per player; drives the r*/p*/s*/go* inputs of the arbiter.
// PARAMETERS
//  SEED         16'hACE1  LFSR reset/start value; a value of 0 is replaced by 16'h0001
//  ROUND_LIMIT  16        rounds per start request (>=1)
//  GAP_CYCLES   2         idle cycles between rounds (0 = back-to-back)
//  TIMEOUT      64        max cycles go may wait for dut_busy before error (>=2)
// PORTS
//  clk          in   1   clock, posedge
//  rst          in   1   asynchronous reset, active-high
//  start        in   1   1-cycle request to play ROUND_LIMIT rounds; honoured only in IDLE/DONE
//  mode         in   1   0 = random (LFSR), 1 = fixed (fixed_move)
//  fixed_move   in   2   00 rock, 01 paper, 10 scissors, 11 treated as rock
//  dut_busy     in   1   arbiter busy; high while the arbiter scores the round
//  r, p, s      out  1   one-hot move; all 0 when no move is presented
//  go           out  1   move valid / player ready
//  rounds_done  out  16  rounds completed since the last accepted start
//  done         out  1   level; ROUND_LIMIT rounds completed
//  err          out  1   sticky timeout flag; cleared by the next accepted start or by rst
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; r=p=s=go=0; rounds_done=0; done=0; err=0;
//   lfsr=SEED (or 1 if SEED==0); gap/timeout counters=0. Applies mid-round too; no partial round is counted.
//  LFSR: 16-bit Galois, right shift, taps mask 16'hB400. It advances exactly once per cycle in PICK only.
//  FSM (all outputs registered):
//   IDLE:  on start -> PICK; clear rounds_done, done, err.
//   PICK:  candidate = mode ? fixed_move : lfsr[1:0], using the current (pre-step) lfsr.
//          Random candidate 11: reject and stay in PICK (lfsr steps).
//          Valid candidate: load one-hot r/p/s, go=1, timer=0 -> ARMED. Fixed mode never rejects.
//   ARMED: go=1, move stable; timer++ each cycle.
//          dut_busy sampled 1 -> go=0 (move still held) -> WAIT.
//          Else, if timer==TIMEOUT-1: go=0, r=p=s=0, err=1 -> IDLE. go is high exactly TIMEOUT cycles.
//   WAIT:  move held, go=0. dut_busy sampled 0 -> r=p=s=0, rounds_done++;
//          if new rounds_done==ROUND_LIMIT: done=1 -> DONE; else -> GAP (-> PICK directly if GAP_CYCLES==0).
//   GAP:   all outputs idle for GAP_CYCLES cycles -> PICK.
//   DONE:  done=1 held; on start -> PICK with rounds_done=0, done=0, err=0.
//  start outside IDLE/DONE is ignored. dut_busy outside ARMED/WAIT is ignored.
//  Invariants: r+p+s <= 1 every cycle; go=1 implies r+p+s==1; the move never changes between go rise and WAIT exit.
//  Latency: start -> go rises 2 cycles later (fixed mode). Busy fall -> next go after GAP_CYCLES+2 cycles (fixed).
//  rounds_done saturates at 16'hFFFF. ROUND_LIMIT bounds it in practice.
// TESTING
//  1 Fixed mode, fixed_move=01, ROUND_LIMIT=3, busy model pulses busy 2 cycles after go for 1 cycle
//    -> three rounds with only p=1; rounds_done steps 1,2,3; done=1; err=0.
//  2 Random mode, SEED=16'hACE1, 20 rounds vs bench Galois-LFSR model
//    -> identical move sequence; code 11 never emitted; one-hot invariant holds every cycle.
//  3 dut_busy tied 0, TIMEOUT=16 -> go high exactly 16 cycles, then go=r=p=s=0, err=1, state IDLE;
//    next start clears err.
//  4 rst pulsed while in WAIT with p=1 -> all outputs 0 asynchronously (before the next clk edge);
//    rounds_done=0; lfsr back to SEED.
//  5 fixed_move=11 -> r=1 only. start pulsed during ARMED -> ignored, rounds_done unaffected.
//  6 GAP_CYCLES=0, busy returns 1 cycle after go
//    -> next go asserted 2 cycles after busy falls; no cycle shows go=1 with r=p=s=0.

Source files
------------

// File: rtl/rps_if.sv
// Player-to-arbiter link for one rock-paper-scissors player.
interface rps_if;
  logic        start;
  logic        mode;
  logic [1:0]  fixed_move;
  logic        dut_busy;
  logic        r;
  logic        p;
  logic        s;
  logic        go;
  logic [15:0] rounds_done;
  logic        done;
  logic        err;

  // Player side: drives the move and status, receives control and busy.
  modport master (
    input  start, mode, fixed_move, dut_busy,
    output r, p, s, go, rounds_done, done, err
  );

  // Controller/arbiter side.
  modport slave (
    output start, mode, fixed_move, dut_busy,
    input  r, p, s, go, rounds_done, done, err
  );
endinterface

// File: rtl/rps_player.sv
// Rock-paper-scissors player: picks a move (LFSR or fixed), presents it with go,
// holds it through the arbiter's busy pulse and counts completed rounds.
module rps_player #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned ROUND_LIMIT = 16,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic   clk,
  input  logic   rst,
  rps_if.master  bus
);

  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LFSR_W-1:0] TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_ARMED, S_WAIT, S_GAP, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [2:0]          move_q, move_d;   // {r, p, s}
  logic                go_q, go_d;
  logic [CNT_W-1:0]    rounds_q, rounds_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [1:0]          cand_c;
  logic                cand_ok_c;
  logic [2:0]          onehot_c;
  logic                timeout_c;
  logic                gap_end_c;
  logic [CNT_W-1:0]    rounds_inc_c;
  logic                last_round_c;
  logic [LFSR_W-1:0]   lfsr_step_c;

  // Shared decode: candidate move, LFSR step, counter terminal conditions.
  always_comb begin
    cand_c       = bus.mode ? bus.fixed_move : lfsr_q[1:0];
    cand_ok_c    = bus.mode || (lfsr_q[1:0] != 2'b11);
    unique case (cand_c)
      2'b01:   onehot_c = 3'b010;
      2'b10:   onehot_c = 3'b001;
      default: onehot_c = 3'b100;   // 00 and fixed-mode 11 both mean rock
    endcase
    lfsr_step_c  = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    timeout_c    = (timer_q == TMR_W'(TIMEOUT - 1));
    gap_end_c    = (gap_q == GAP_W'(GAP_CYCLES - 1));
    rounds_inc_c = (rounds_q == '1) ? rounds_q : rounds_q + CNT_W'(1);
    last_round_c = (rounds_inc_c == CNT_W'(ROUND_LIMIT));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_PICK;
      S_PICK:  if (cand_ok_c) state_d = S_ARMED;
      S_ARMED: begin
        if (bus.dut_busy)  state_d = S_WAIT;
        else if (timeout_c) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (!bus.dut_busy) begin
          if (last_round_c)          state_d = S_DONE;
          else if (GAP_CYCLES == 0)  state_d = S_PICK;
          else                       state_d = S_GAP;
        end
      end
      S_GAP:   if (gap_end_c) state_d = S_PICK;
      S_DONE:  if (bus.start) state_d = S_PICK;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    lfsr_d   = lfsr_q;
    move_d   = move_q;
    go_d     = go_q;
    rounds_d = rounds_q;
    done_d   = done_q;
    err_d    = err_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          rounds_d = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_PICK: begin
        lfsr_d = lfsr_step_c;
        if (cand_ok_c) begin
          move_d  = onehot_c;
          go_d    = 1'b1;
          timer_d = '0;
        end
      end
      S_ARMED: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.dut_busy) begin
          go_d = 1'b0;
        end else if (timeout_c) begin
          go_d   = 1'b0;
          move_d = '0;
          err_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.dut_busy) begin
          move_d   = '0;
          rounds_d = rounds_inc_c;
          gap_d    = '0;
          if (last_round_c) done_d = 1'b1;
        end
      end
      S_GAP:   gap_d = gap_q + GAP_W'(1);
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= SEED_EFF;
      move_q   <= '0;
      go_q     <= 1'b0;
      rounds_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      gap_q    <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      move_q   <= move_d;
      go_q     <= go_d;
      rounds_q <= rounds_d;
      done_q   <= done_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.r           = move_q[2];
  assign bus.p           = move_q[1];
  assign bus.s           = move_q[0];
  assign bus.go          = go_q;
  assign bus.rounds_done = rounds_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
